// File: rtl/pi_pkg.sv
// Shared constants and arithmetic helpers for the multi-channel PI pipeline.
package pi_pkg;
  localparam int NUM_STAGES = 5;
  // Wide enough to hold any product sum plus headroom for the helpers below.
  localparam int LIM_W = 128;
  typedef logic signed [LIM_W-1:0] lim_t;

  function automatic lim_t clamp_max(input int r);
    return (lim_t'(1) <<< (r - 1)) - lim_t'(1);
  endfunction

  function automatic lim_t clamp_min(input int r);
    return -(lim_t'(1) <<< (r - 1));
  endfunction

  // Signed add that saturates to the w-bit signed range instead of wrapping.
  function automatic lim_t sat_add(input lim_t a, input lim_t b, input int w);
    lim_t s;
    s = a + b;
    if (s > clamp_max(w)) return clamp_max(w);
    if (s < clamp_min(w)) return clamp_min(w);
    return s;
  endfunction
endpackage

// File: rtl/pi_pipeline_mc_clamp.sv
// Final-stage fixed-point shift, range clamp and saturation flags (combinational).
module pi_clamp
  import pi_pkg::*;
#(
  parameter int IN_WIDTH          = 65,
  parameter int OUTPUT_WIDTH      = 32,
  parameter int OUTPUT_RANGE_BITS = 20,
  parameter int FRAC_BITS         = 0
) (
  input  logic signed [IN_WIDTH-1:0]     sum_i,
  output logic signed [OUTPUT_WIDTH-1:0] result_o,
  output logic                           sat_high_o,
  output logic                           sat_low_o
);
  localparam logic signed [IN_WIDTH-1:0] MAX_V = IN_WIDTH'(clamp_max(OUTPUT_RANGE_BITS));
  localparam logic signed [IN_WIDTH-1:0] MIN_V = IN_WIDTH'(clamp_min(OUTPUT_RANGE_BITS));

  logic signed [IN_WIDTH-1:0] shifted;

  always_comb begin
    shifted    = sum_i >>> FRAC_BITS;
    sat_high_o = shifted > MAX_V;
    sat_low_o  = shifted < MIN_V;
    if (sat_high_o)     result_o = OUTPUT_WIDTH'(MAX_V);
    else if (sat_low_o) result_o = OUTPUT_WIDTH'(MIN_V);
    else                result_o = OUTPUT_WIDTH'(shifted);
  end
endmodule

// File: rtl/pi_pipeline_mc.sv
// Time-multiplexed PI controller: per-channel integrators, saturating integrate,
// clamped output with anti-windup, and a same-channel issue interlock.
module pi_pipeline_mc
  import pi_pkg::*;
#(
  parameter int NUM_CHANNELS      = 4,
  parameter int INPUT_WIDTH       = 18,
  parameter int OUTPUT_WIDTH      = 32,
  parameter int OUTPUT_RANGE_BITS = 20,
  parameter int FRAC_BITS         = 0,
  localparam int CH_W             = $clog2(NUM_CHANNELS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CH_W-1:0]                in_channel,
  input  logic                           int_clear,
  input  logic signed [OUTPUT_WIDTH-1:0] kp,
  input  logic signed [OUTPUT_WIDTH-1:0] ki,
  input  logic signed [INPUT_WIDTH-1:0]  setpoint,
  input  logic signed [INPUT_WIDTH-1:0]  actual,
  output logic                           out_valid,
  output logic [CH_W-1:0]                out_channel,
  output logic signed [OUTPUT_WIDTH-1:0] pi_result,
  output logic signed [OUTPUT_WIDTH-1:0] integral_result,
  output logic                           sat_high,
  output logic                           sat_low
);
  localparam int OW = OUTPUT_WIDTH;
  localparam int PW = 2 * OW;
  localparam int SW = 2 * OW + 1;

  logic [NUM_STAGES:1] vld_q, vld_d;
  logic [NUM_CHANNELS-1:0][OW-1:0] integ_q, integ_d;

  logic signed [OW-1:0] err1_q, err1_d, kp1_q, kp1_d, ki1_q, ki1_d;
  logic [CH_W-1:0]      ch1_q, ch1_d;
  logic                 clr1_q, clr1_d;

  logic signed [OW-1:0] inext2_q, inext2_d, base2_q, base2_d, err2_q, err2_d;
  logic signed [OW-1:0] kp2_q, kp2_d, ki2_q, ki2_d;
  logic [CH_W-1:0]      ch2_q, ch2_d;

  logic signed [PW-1:0] wi3_q, wi3_d, wp3_q, wp3_d;
  logic signed [OW-1:0] err3_q, err3_d, base3_q, base3_d, inext3_q, inext3_d;
  logic [CH_W-1:0]      ch3_q, ch3_d;

  logic signed [SW-1:0] sum4_q, sum4_d;
  logic signed [OW-1:0] err4_q, err4_d, base4_q, base4_d, inext4_q, inext4_d;
  logic [CH_W-1:0]      ch4_q, ch4_d;

  logic [CH_W-1:0]      out_ch_q, out_ch_d;
  logic signed [OW-1:0] pi_q, pi_d, int_q, int_d;
  logic                 sh_q, sh_d, sl_q, sl_d;

  logic signed [OW-1:0] base_s, commit;
  logic signed [OW-1:0] clamp_res;
  logic                 clamp_sh, clamp_sl, hazard, accept, inhibit;

  pi_clamp #(
    .IN_WIDTH(SW), .OUTPUT_WIDTH(OW),
    .OUTPUT_RANGE_BITS(OUTPUT_RANGE_BITS), .FRAC_BITS(FRAC_BITS)
  ) u_clamp (
    .sum_i(sum4_q), .result_o(clamp_res), .sat_high_o(clamp_sh), .sat_low_o(clamp_sl)
  );

  // The S4 holder writes back on the next edge, before a new sample reads in S2,
  // so only the three younger stages need to block a same-channel issue.
  always_comb begin
    hazard = (vld_q[1] && ch1_q == in_channel) ||
             (vld_q[2] && ch2_q == in_channel) ||
             (vld_q[3] && ch3_q == in_channel);
    in_ready = !rst && !hazard;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    vld_d  = {vld_q[NUM_STAGES-1:1], accept};

    err1_d = OW'(actual) - OW'(setpoint);
    kp1_d  = kp;
    ki1_d  = ki;
    ch1_d  = in_channel;
    clr1_d = int_clear;

    base_s   = clr1_q ? '0 : $signed(integ_q[ch1_q]);
    base2_d  = base_s;
    inext2_d = OW'(sat_add(lim_t'(base_s), lim_t'(err1_q), OW));
    err2_d   = err1_q;
    kp2_d    = kp1_q;
    ki2_d    = ki1_q;
    ch2_d    = ch1_q;

    wi3_d    = PW'(inext2_q) * PW'(ki2_q);
    wp3_d    = PW'(err2_q) * PW'(kp2_q);
    err3_d   = err2_q;
    base3_d  = base2_q;
    inext3_d = inext2_q;
    ch3_d    = ch2_q;

    sum4_d   = SW'(wi3_q) + SW'(wp3_q);
    err4_d   = err3_q;
    base4_d  = base3_q;
    inext4_d = inext3_q;
    ch4_d    = ch3_q;

    // Freeze the integrator when it would only push further into saturation.
    inhibit  = (clamp_sh && err4_q > 0) || (clamp_sl && err4_q < 0);
    commit   = inhibit ? base4_q : inext4_q;
    integ_d  = integ_q;
    out_ch_d = out_ch_q;
    pi_d     = pi_q;
    int_d    = int_q;
    sh_d     = sh_q;
    sl_d     = sl_q;
    if (vld_q[4]) begin
      integ_d[ch4_q] = commit;
      out_ch_d       = ch4_q;
      pi_d           = clamp_res;
      int_d          = commit;
      sh_d           = clamp_sh;
      sl_d           = clamp_sl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q    <= '0;
      integ_q  <= '0;
      out_ch_q <= '0;
      pi_q     <= '0;
      int_q    <= '0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      integ_q  <= integ_d;
      out_ch_q <= out_ch_d;
      pi_q     <= pi_d;
      int_q    <= int_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
    end
  end

  always_ff @(posedge clk) begin
    err1_q   <= err1_d;   kp1_q   <= kp1_d;   ki1_q    <= ki1_d;
    ch1_q    <= ch1_d;    clr1_q  <= clr1_d;
    inext2_q <= inext2_d; base2_q <= base2_d; err2_q   <= err2_d;
    kp2_q    <= kp2_d;    ki2_q   <= ki2_d;   ch2_q    <= ch2_d;
    wi3_q    <= wi3_d;    wp3_q   <= wp3_d;   err3_q   <= err3_d;
    base3_q  <= base3_d;  inext3_q <= inext3_d; ch3_q  <= ch3_d;
    sum4_q   <= sum4_d;   err4_q  <= err4_d;  base4_q  <= base4_d;
    inext4_q <= inext4_d; ch4_q   <= ch4_d;
  end

  assign out_valid       = vld_q[NUM_STAGES];
  assign out_channel     = out_ch_q;
  assign pi_result       = pi_q;
  assign integral_result = int_q;
  assign sat_high        = sh_q;
  assign sat_low         = sl_q;
endmodule
